// File: rtl/pdm_cic_decimator.sv
// -----------------------------------------------------------------------------
// pdm_cic_decimator
//   Third-order CIC (sinc3) decimator that turns a strobed 1-bit PDM stream
//   into 16-bit signed PCM. Differential delay 1, decimation ratio R = 2**LOG2R.
//   Everything runs in the clk domain; PDM bits arrive as pdm_valid strobes.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active high (priority over ce)
//   ce         clock enable; low freezes all state
//   pdm_i      PDM data bit, taken when ce && pdm_valid
//   pdm_valid  one-cycle strobe per PDM sample
//   pcm_o      signed PCM result, held between updates
//   pcm_valid  one-cycle pulse when pcm_o carries a new settled result
//   sat_o      pulses together with pcm_valid when the result was clipped
// -----------------------------------------------------------------------------
module pdm_cic_decimator #(
    parameter int unsigned LOG2R = 6,
    parameter int unsigned SHIFT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               pdm_i,
    input  logic               pdm_valid,
    output logic signed [15:0] pcm_o,
    output logic               pcm_valid,
    output logic               sat_o
);

    // Integrator/comb width is tied to the filter gain R**3 plus sign and
    // headroom; it is derived rather than overridable.
    localparam int unsigned ACC_W = 3 * LOG2R + 2;

    localparam logic signed [ACC_W-1:0] PCM_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] PCM_MIN = ACC_W'(-32768);

    // The first two comb outputs after reset see partially filled delays.
    typedef enum logic [1:0] {
        ST_WAIT1,
        ST_WAIT2,
        ST_RUN
    } settle_e;

    settle_e                  settle_q, settle_d;

    logic signed [ACC_W-1:0]  i1_q, i1_d;
    logic signed [ACC_W-1:0]  i2_q, i2_d;
    logic signed [ACC_W-1:0]  i3_q, i3_d;
    logic signed [ACC_W-1:0]  d1_q, d1_d;
    logic signed [ACC_W-1:0]  d2_q, d2_d;
    logic signed [ACC_W-1:0]  d3_q, d3_d;
    logic [LOG2R-1:0]         dcnt_q, dcnt_d;
    logic                     tick_q, tick_d;
    logic signed [15:0]       pcm_q, pcm_d;
    logic                     valid_q, valid_d;
    logic                     sat_q, sat_d;

    logic signed [ACC_W-1:0]  x;
    logic signed [ACC_W-1:0]  c1, c2, c3;
    logic signed [ACC_W-1:0]  y;
    logic signed [15:0]       y_sat;
    logic                     clip;

    // Datapath: input mapping, comb chain and output saturation.
    always_comb begin
        x  = pdm_i ? ACC_W'(1) : '1;

        c1 = i3_q - d1_q;
        c2 = c1 - d2_q;
        c3 = c2 - d3_q;
        y  = c3 >>> SHIFT;

        if (y > PCM_MAX) begin
            y_sat = 16'sh7fff;
            clip  = 1'b1;
        end else if (y < PCM_MIN) begin
            y_sat = 16'sh8000;
            clip  = 1'b1;
        end else begin
            y_sat = y[15:0];
            clip  = 1'b0;
        end
    end

    // Next state assuming ce=1; the register block applies ce as a freeze.
    always_comb begin
        i1_d    = i1_q;
        i2_d    = i2_q;
        i3_d    = i3_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        dcnt_d  = dcnt_q;
        tick_d  = 1'b0;
        pcm_d   = pcm_q;
        valid_d = 1'b0;
        sat_d   = 1'b0;

        if (pdm_valid) begin
            i1_d   = i1_q + x;
            i2_d   = i2_q + i1_d;
            i3_d   = i3_q + i2_d;
            dcnt_d = dcnt_q + 1'b1;
            tick_d = (dcnt_q == '1);
        end

        // The comb reads the pre-update I3: that is the value after the
        // R-th sample even if another sample is accepted this cycle.
        if (tick_q) begin
            d1_d    = i3_q;
            d2_d    = c1;
            d3_d    = c2;
            pcm_d   = y_sat;
            valid_d = (settle_q == ST_RUN);
            sat_d   = (settle_q == ST_RUN) && clip;
        end
    end

    always_comb begin
        settle_d = settle_q;
        if (tick_q) begin
            case (settle_q)
                ST_WAIT1: settle_d = ST_WAIT2;
                ST_WAIT2: settle_d = ST_RUN;
                ST_RUN:   settle_d = ST_RUN;
                default:  settle_d = ST_WAIT1;
            endcase
        end
    end

    // With ce low nothing advances, so a pending tick (or an undelivered
    // valid pulse) simply waits for the next enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            i1_q     <= '0;
            i2_q     <= '0;
            i3_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            d3_q     <= '0;
            dcnt_q   <= '0;
            tick_q   <= 1'b0;
            pcm_q    <= '0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
            settle_q <= ST_WAIT1;
        end else if (ce) begin
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            i3_q     <= i3_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            d3_q     <= d3_d;
            dcnt_q   <= dcnt_d;
            tick_q   <= tick_d;
            pcm_q    <= pcm_d;
            valid_q  <= valid_d;
            sat_q    <= sat_d;
            settle_q <= settle_d;
        end
    end

    // A held valid pulse must not show while ce is low; it appears on the
    // first enabled cycle and is consumed by that cycle's edge.
    assign pcm_o     = pcm_q;
    assign pcm_valid = valid_q & ce;
    assign sat_o     = sat_q & ce;

endmodule
